// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the multi-byte UART packet transmitter.
// Build option: UART_TX_CKSUM_EN inserts a checksum byte before the tail.
package uart_pkt_pkg;

    localparam logic [7:0] UART_PKT_HEAD = 8'hA5;
    localparam logic [7:0] UART_PKT_TAIL = 8'h5A;

    // pack_num, dataA, dataB hi/lo, dataC hi/lo, dataD
    localparam int unsigned UART_PKT_PAYLOAD_BYTES = 7;

`ifdef UART_TX_CKSUM_EN
    localparam int unsigned UART_PKT_BYTES = UART_PKT_PAYLOAD_BYTES + 3;
`else
    localparam int unsigned UART_PKT_BYTES = UART_PKT_PAYLOAD_BYTES + 2;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StLoadByte,
        StShift,
        StDone
    } pkt_state_e;

    // Packet contents captured at accept; immune to later input changes
    typedef struct packed {
        logic [7:0]  pnum;
        logic [7:0]  a;
        logic [15:0] b;
        logic [15:0] c;
        logic [7:0]  d;
    } pkt_shadow_t;

`ifdef UART_TX_CKSUM_EN
    // 8-bit modular sum of the payload bytes, carries discarded
    function automatic logic [7:0] pkt_cksum(input pkt_shadow_t s);
        logic [7:0] sum;
        sum = s.pnum + s.a + s.b[15:8] + s.b[7:0] + s.c[15:8] + s.c[7:0] + s.d;
        return sum;
    endfunction
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serialiser: baud counter plus shifter, LSB first.
// byte_ready pulses in the last cycle of the stop bit; a byte_valid in that
// same cycle chains the next frame with no idle gap.
module uart_byte_tx #(
    parameter int unsigned BPS_CNT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       txd
);

    localparam int unsigned     CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic [3:0]      BIT_STOP = 4'd9;

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    // Data bits then stop bit; the start bit is driven directly at load
    logic [8:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             bit_end;
    logic             load;

    // Next-state: load a new frame, or advance the baud counter and bit position
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;

        bit_end    = active_q && (cnt_q == CNT_MAX);
        byte_ready = bit_end && (bit_q == BIT_STOP);
        load       = byte_valid && (!active_q || byte_ready);

        if (load) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = 4'd0;
            shift_d  = {1'b1, byte_data};
            txd_d    = 1'b0;
        end else if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_q == BIT_STOP) begin
                    active_d = 1'b0;
                    txd_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State register; line idles high out of reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '1;
            txd_q    <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART packet transmitter: sequencer FSM, shadow register,
// byte mux and optional checksum over an 8N1 byte serialiser.
// Build option: UART_TX_CKSUM_EN adds a checksum byte before the tail.
module uart_mult_byte_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        send_req,
    input  logic [7:0]  dataA,
    input  logic [15:0] dataB,
    input  logic [15:0] dataC,
    input  logic [7:0]  dataD,
    output logic        uart_txd,
    output logic        busy,
    output logic        tx_done,
    output logic [7:0]  pack_num
);

    import uart_pkt_pkg::*;

    localparam int unsigned BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam logic [3:0]  LAST_IDX = 4'(UART_PKT_BYTES - 1);

    pkt_state_e  state_q, state_d;
    pkt_shadow_t shadow_q, shadow_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  pack_num_q, pack_num_d;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic [3:0] sel_idx;
    logic [7:0] sel_byte;

    // Byte mux addressed by the index of the byte that follows the current one,
    // so the next byte is ready the instant the stop bit finishes
    always_comb begin
        sel_idx = idx_q + 4'd1;
        case (sel_idx)
            4'd1:    sel_byte = shadow_q.pnum;
            4'd2:    sel_byte = shadow_q.a;
            4'd3:    sel_byte = shadow_q.b[15:8];
            4'd4:    sel_byte = shadow_q.b[7:0];
            4'd5:    sel_byte = shadow_q.c[15:8];
            4'd6:    sel_byte = shadow_q.c[7:0];
            4'd7:    sel_byte = shadow_q.d;
`ifdef UART_TX_CKSUM_EN
            4'd8:    sel_byte = pkt_cksum(shadow_q);
`endif
            default: sel_byte = UART_PKT_TAIL;
        endcase
    end

    // Packet sequencer: accept, hand bytes to the serialiser, finish
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        pack_num_d = pack_num_q;
        byte_valid = 1'b0;
        byte_data  = sel_byte;

        unique case (state_q)
            StIdle, StDone: begin
                if (send_req) begin
                    // HEAD is constant, so it can start before the shadow is loaded
                    state_d    = StLoadByte;
                    shadow_d   = '{pnum: pack_num_q + 8'd1, a: dataA, b: dataB,
                                   c: dataC, d: dataD};
                    idx_d      = 4'd0;
                    byte_valid = 1'b1;
                    byte_data  = UART_PKT_HEAD;
                end else begin
                    state_d = StIdle;
                end
            end
            StLoadByte, StShift: begin
                state_d = StShift;
                if (byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = StDone;
                        pack_num_d = shadow_q.pnum;
                    end else begin
                        state_d    = StLoadByte;
                        idx_d      = sel_idx;
                        byte_valid = 1'b1;
                    end
                end
            end
        endcase
    end

    // Sequencer state, shadow and packet counter registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            shadow_q   <= '0;
            idx_q      <= 4'd0;
            pack_num_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            pack_num_q <= pack_num_d;
        end
    end

    uart_byte_tx #(
        .BPS_CNT (BPS_CNT)
    ) u_byte_tx (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .txd        (uart_txd)
    );

    assign busy     = (state_q == StLoadByte) || (state_q == StShift);
    assign tx_done  = (state_q == StDone);
    assign pack_num = pack_num_q;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Testbench for uart_mult_byte_tx. Runs at a reduced bit time so that a
// 256-packet wrap fits in a short simulation. Honours UART_TX_CKSUM_EN.
module tb_uart_mult_byte_tx;

    localparam int unsigned CLK_FREQ = 200;
    localparam int unsigned UART_BPS = 100;
    localparam int          B        = 2;   // cycles per bit
`ifdef UART_TX_CKSUM_EN
    localparam int          NB       = 10;
`else
    localparam int          NB       = 9;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        send_req = 1'b0;
    logic [7:0]  dataA = 8'h00;
    logic [15:0] dataB = 16'h0000;
    logic [15:0] dataC = 16'h0000;
    logic [7:0]  dataD = 8'h00;
    logic        uart_txd;
    logic        busy;
    logic        tx_done;
    logic [7:0]  pack_num;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  shown_pnum = 8'h00;  // model of the pack_num output
    logic        poke_en = 1'b0;

    uart_mult_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .send_req (send_req),
        .dataA    (dataA),
        .dataB    (dataB),
        .dataC    (dataC),
        .dataD    (dataD),
        .uart_txd (uart_txd),
        .busy     (busy),
        .tx_done  (tx_done),
        .pack_num (pack_num)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Bench UART receiver: one frame, sampled on every cycle of every bit.
    // Optionally pokes send_req/dataA mid-frame to show they are ignored.
    task automatic rx_byte(output logic [9:0] bits, output logic glitch, output logic side_bad);
        glitch   = 1'b0;
        side_bad = 1'b0;
        bits     = '0;
        for (int j = 0; j < 10; j++) begin
            bits[j] = uart_txd;
            for (int k = 0; k < B; k++) begin
                if (uart_txd !== bits[j]) glitch = 1'b1;
                if (busy !== 1'b1 || tx_done !== 1'b0 || pack_num !== shown_pnum) side_bad = 1'b1;
                if (poke_en && j == 5 && k == 0) begin
                    send_req = 1'b1;
                    dataA    = 8'($urandom);
                end else if (poke_en && j == 6 && k == 0) begin
                    send_req = 1'b0;
                end
                tick();
            end
        end
    endtask

    // Send one packet and decode it; leaves the bench in the DONE cycle.
    task automatic xfer(input logic [7:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [7:0] d, input logic hold, input string tag);
        logic [7:0] pn;
        logic [7:0] ck;
        logic [7:0] exp_b;
        logic [9:0] bits;
        logic       gl;
        logic       sbad;
        pn = shown_pnum + 8'd1;
        ck = pn + a + b[15:8] + b[7:0] + c[15:8] + c[7:0] + d;
        sb_q.push_back(8'hA5);
        sb_q.push_back(pn);
        sb_q.push_back(a);
        sb_q.push_back(b[15:8]);
        sb_q.push_back(b[7:0]);
        sb_q.push_back(c[15:8]);
        sb_q.push_back(c[7:0]);
        sb_q.push_back(d);
`ifdef UART_TX_CKSUM_EN
        sb_q.push_back(ck);
`endif
        sb_q.push_back(8'h5A);

        dataA    = a;
        dataB    = b;
        dataC    = c;
        dataD    = d;
        send_req = 1'b1;
        tick();
        if (!hold) send_req = 1'b0;

        for (int i = 0; i < NB; i++) begin
            exp_b = sb_q.pop_front();
            rx_byte(bits, gl, sbad);
            n_checks++;
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || gl || bits[8:1] !== exp_b)
                $display("FAIL %s byte%0d: got frame %b (glitch=%0d) exp data %h", tag, i,
                         bits, gl, exp_b);
            else n_pass++;
            n_checks++;
            if (sbad)
                $display("FAIL %s status byte%0d: busy/tx_done/pack_num wrong in flight (%b/%b/%h, exp 1/0/%h)",
                         tag, i, busy, tx_done, pack_num, shown_pnum);
            else n_pass++;
        end

        n_checks++;
        if (tx_done !== 1'b1 || busy !== 1'b0 || pack_num !== pn)
            $display("FAIL %s done: tx_done=%b busy=%b pack_num=%h exp 1/0/%h", tag, tx_done,
                     busy, pack_num, pn);
        else n_pass++;
        shown_pnum = pn;
    endtask

    task automatic check_idle(input string tag);
        tick();
        n_checks++;
        if (busy !== 1'b0 || tx_done !== 1'b0 || uart_txd !== 1'b1 || pack_num !== shown_pnum)
            $display("FAIL %s idle: busy=%b tx_done=%b txd=%b pack_num=%h exp 0/0/1/%h", tag,
                     busy, tx_done, uart_txd, pack_num, shown_pnum);
        else n_pass++;
    endtask

    task automatic test_reset();
        int bad;
        sys_rst = 1'b1;
        repeat (3) tick();
        sys_rst = 1'b0;
        shown_pnum = 8'h00;
        n_checks++;
        if (uart_txd !== 1'b1) $display("FAIL reset txd: got %b exp 1", uart_txd);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b exp 0", busy);
        else n_pass++;
        n_checks++;
        if (tx_done !== 1'b0) $display("FAIL reset tx_done: got %b exp 0", tx_done);
        else n_pass++;
        n_checks++;
        if (pack_num !== 8'h00) $display("FAIL reset pack_num: got %h exp 00", pack_num);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            if (uart_txd !== 1'b1 || busy !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL quiet line: %0d bad cycles exp 0", bad);
        else n_pass++;
    endtask

    task automatic test_single();
        xfer(8'h08, 16'h1234, 16'hABCD, 8'h5A, 1'b0, "single");
        check_idle("single");
    endtask

    task automatic test_back_to_back();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        shown_pnum = 8'h00;
        for (int p = 0; p < 256; p++)
            xfer(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 1'b1, "b2b");
        send_req = 1'b0;
        n_checks++;
        if (pack_num !== 8'h00) $display("FAIL wrap pack_num: got %h exp 00", pack_num);
        else n_pass++;
        check_idle("b2b");
    endtask

    task automatic test_ignore_busy();
        poke_en = 1'b1;
        xfer(8'hC3, 16'h0FF0, 16'h8001, 8'h7E, 1'b0, "ignore");
        poke_en = 1'b0;
        check_idle("ignore");
    endtask

    task automatic test_reset_mid();
        int bad;
        dataA    = 8'h11;
        dataB    = 16'h2233;
        dataC    = 16'h4455;
        dataD    = 8'h66;
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        repeat (4 * 10 * B + 3) tick();
        sys_rst = 1'b1;
        tick();
        n_checks++;
        if (uart_txd !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || pack_num !== 8'h00)
            $display("FAIL mid reset: txd=%b busy=%b tx_done=%b pack_num=%h exp 1/0/0/00",
                     uart_txd, busy, tx_done, pack_num);
        else n_pass++;
        sys_rst = 1'b0;
        shown_pnum = 8'h00;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (uart_txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL post reset resume: %0d bad cycles exp 0", bad);
        else n_pass++;
        xfer(8'h99, 16'hFEDC, 16'h0102, 8'hE7, 1'b0, "fresh");
        check_idle("fresh");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
